// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: CPU load/store front end for a word-wide, fixed-latency
// memory with little-endian byte lanes. Sub-word stores use read-modify-write.
// Optional feature macro: SIGNED_LOAD_EN (sign-extend byte/half loads when
// req_signed = 1). Default build zero-extends all loads.
module mem_access_ctrl #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;
    localparam logic [1:0] SZ_WORD = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                write_q;
    logic [1:0]          size_q;
    logic                signed_q;
    logic [DATA_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic                req_ready_q;
    logic [DATA_W-1:0]   mem_addr_q;
    logic                mem_wr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                resp_valid_q;
    logic [DATA_W-1:0]   resp_data_q;
    logic                resp_err_q;

    logic                misaligned_c;
    logic                sext_c;
    logic [7:0]          lane_byte_c;
    logic [15:0]         lane_half_c;
    logic [DATA_W-1:0]   load_data_c;
    logic [DATA_W-1:0]   merge_data_c;

    assign req_ready  = req_ready_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wr     = mem_wr_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

    // Alignment check on the incoming request (evaluated only in IDLE)
    always_comb begin
        misaligned_c = 1'b0;
        unique case (req_size)
            2'd0:    misaligned_c = 1'b1;
            SZ_HALF: misaligned_c = req_addr[0];
            SZ_WORD: misaligned_c = (req_addr[1:0] != 2'b00);
            default: misaligned_c = 1'b0;
        endcase
    end

`ifdef SIGNED_LOAD_EN
    assign sext_c = signed_q;
`else
    logic unused_signed;
    assign unused_signed = signed_q;
    assign sext_c        = 1'b0;
`endif

    // Lane select and extension of the returned memory word for loads
    always_comb begin
        lane_byte_c = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        lane_half_c = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data_c = mem_rdata;
        unique case (size_q)
            SZ_BYTE: load_data_c = {{24{sext_c & lane_byte_c[7]}}, lane_byte_c};
            SZ_HALF: load_data_c = {{16{sext_c & lane_half_c[15]}}, lane_half_c};
            default: load_data_c = mem_rdata;
        endcase
    end

    // Old word with the addressed lane(s) replaced, for sub-word stores
    always_comb begin
        merge_data_c = mem_rdata;
        unique case (size_q)
            SZ_BYTE: merge_data_c[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            SZ_HALF: begin
                if (addr_q[1]) begin
                    merge_data_c[31:16] = wdata_q[15:0];
                end else begin
                    merge_data_c[15:0] = wdata_q[15:0];
                end
            end
            default: merge_data_c = mem_rdata;
        endcase
    end

    // Access sequencer with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            mem_addr_q   <= '0;
            mem_wr_q     <= 1'b0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q     <= req_write;
                        size_q      <= req_size;
                        signed_q    <= req_signed;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        if (misaligned_c) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (req_write && (req_size == SZ_WORD)) begin
                            state_q     <= WR;
                            mem_addr_q  <= {req_addr[31:2], 2'b00};
                            mem_wr_q    <= 1'b1;
                            mem_wdata_q <= req_wdata;
                        end else begin
                            state_q    <= RD_WAIT;
                            mem_addr_q <= {req_addr[31:2], 2'b00};
                            cnt_q      <= CNT_W'(MEM_WAIT - 1);
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (write_q) begin
                        state_q     <= WR;
                        mem_wr_q    <= 1'b1;
                        mem_wdata_q <= merge_data_c;
                    end else begin
                        state_q      <= RESP;
                        mem_addr_q   <= '0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_data_q  <= load_data_c;
                    end
                end
                WR: begin
                    state_q      <= RESP;
                    mem_addr_q   <= '0;
                    mem_wr_q     <= 1'b0;
                    mem_wdata_q  <= '0;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a reference model computes expected
// responses and memory writes at issue time; a monitor checks them as the DUT
// presents them. Define SIGNED_LOAD_EN to match a sign-extending build.
module tb_mem_access_ctrl;

    localparam int unsigned MEM_WAIT = 2;
`ifdef SIGNED_LOAD_EN
    localparam bit SEXT = 1'b1;
`else
    localparam bit SEXT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    mem_access_ctrl #(.MEM_WAIT(MEM_WAIT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic err; logic [31:0] data; int cyc; } resp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } wr_t;
    resp_t resp_q[$];
    wr_t   wr_q[$];

    logic [31:0] model_mem [64];
    logic [31:0] phys_mem [64];
    logic [31:0] last_load = '0;

    // Physical memory: DUT writes plus a backdoor for preloading
    logic        bd_en = 1'b0;
    logic [5:0]  bd_idx = '0;
    logic [31:0] bd_val = '0;
    always @(posedge clk) begin
        if (bd_en) phys_mem[bd_idx] <= bd_val;
        else if (mem_wr) phys_mem[mem_addr[7:2]] <= mem_wdata;
    end

    // Read data is only valid once an address has been held MEM_WAIT cycles
    logic [31:0] last_addr = '0;
    int          run = 0;
    int          vis;
    always @(posedge clk) begin
        if (mem_addr == last_addr) run <= run + 1;
        else run <= 1;
        last_addr <= mem_addr;
    end
    always_comb begin
        vis = (mem_addr == last_addr) ? run + 1 : 1;
        mem_rdata = (vis >= int'(MEM_WAIT)) ? phys_mem[mem_addr[7:2]] : 32'hBAD0_BAD0;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT responds or writes memory
    always @(negedge clk) begin
        resp_t r;
        wr_t   w;
        if (!reset) begin
            if (resp_valid) begin
                if (resp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp at cycle %0d", cyc);
                end else begin
                    r = resp_q.pop_front();
                    check("resp_err", 32'(resp_err), 32'(r.err));
                    check("resp_data", resp_data, r.data);
                    check("resp_cycle", 32'(cyc), 32'(r.cyc));
                    check("resp_mem_addr", mem_addr, 32'h0);
                end
            end
            if (mem_wr) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_mem_wr at cycle %0d addr %h", cyc, mem_addr);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_addr", mem_addr, w.addr);
                    check("wr_data", mem_wdata, w.data);
                    check("wr_cycle", 32'(cyc), 32'(w.cyc));
                end
            end else begin
                check("idle_wdata", mem_wdata, 32'h0);
            end
        end
    end

    task automatic set_word(input int idx, input logic [31:0] v);
        model_mem[idx] = v;
        bd_en = 1'b1; bd_idx = 6'(idx); bd_val = v;
        @(negedge clk);
        bd_en = 1'b0;
    endtask

    // Reference model: expected response and memory write from plain arithmetic
    task automatic model_push(input logic w, input logic [1:0] sz, input logic sgn,
                              input logic [31:0] a, input logic [31:0] wd, input int acc);
        logic [31:0] word, val, mask, nw;
        int sh, lat;
        bit mis;
        word = model_mem[a[7:2]];
        mis = (sz == 2'd0) || (sz == 2'd2 && a[0]) || (sz == 2'd3 && a[1:0] != 2'b00);
        if (mis) begin
            resp_q.push_back('{1'b1, last_load, acc + 1});
        end else if (!w) begin
            if (sz == 2'd1) begin
                val = (word >> (8 * int'(a[1:0]))) & 32'hFF;
                if (SEXT && sgn && val[7]) val = val | 32'hFFFF_FF00;
            end else if (sz == 2'd2) begin
                val = (word >> (16 * int'(a[1]))) & 32'hFFFF;
                if (SEXT && sgn && val[15]) val = val | 32'hFFFF_0000;
            end else begin
                val = word;
            end
            last_load = val;
            resp_q.push_back('{1'b0, val, acc + int'(MEM_WAIT) + 1});
        end else begin
            if (sz == 2'd3) begin
                nw = wd; lat = 2;
            end else begin
                sh   = (sz == 2'd1) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
                mask = ((sz == 2'd1) ? 32'hFF : 32'hFFFF) << sh;
                nw   = (word & ~mask) | ((wd << sh) & mask);
                lat  = int'(MEM_WAIT) + 2;
            end
            model_mem[a[7:2]] = nw;
            wr_q.push_back('{a & ~32'h3, nw, acc + lat - 1});
            resp_q.push_back('{1'b0, last_load, acc + lat});
        end
    endtask

    // Present a request at a negedge and wait (bounded) for acceptance
    task automatic issue(input logic w, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] a, input logic [31:0] wd,
                         input bit hold, output int acc);
        int n;
        n = 0;
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sgn;
        req_addr = a; req_wdata = wd;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            if (!w) req_wdata = $urandom;
            n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout at cycle %0d", cyc);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc;
        model_push(w, sz, sgn, a, req_wdata, acc);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    // While busy, drive garbage with valid high; drop valid once ready
    task automatic busy_wait();
        for (int i = 0; i < 100; i++) begin
            if (req_ready) begin
                req_valid = 1'b0;
                return;
            end
            req_valid = 1'b1; req_write = 1'($urandom); req_size = 2'($urandom);
            req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
            @(negedge clk);
        end
        checks++; errors++;
        $display("FAIL busy_timeout at cycle %0d", cyc);
        req_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'h1);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_mem_wr"}, 32'(mem_wr), 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
        check({tag, "_resp_data"}, resp_data, 32'h0);
        check({tag, "_resp_err"}, 32'(resp_err), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc_a, acc_b, bad;
        logic [31:0] sv;

        #2 reset = 1'b1;
        #1 check_reset_outputs("por");
        for (int i = 0; i < 64; i++) set_word(i, $urandom);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Word load at 0x10
        set_word(32'h10 >> 2, 32'hDEAD_BEEF);
        issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 1'b0, acc_a);
        busy_wait();

        // Signed byte load from lane 3
        set_word(32'h10 >> 2, 32'h80FF_1234);
        issue(1'b0, 2'd1, 1'b1, 32'h13, 32'h0, 1'b0, acc_a);
        busy_wait();
        check("byte_load_ext", resp_data, SEXT ? 32'hFFFF_FF80 : 32'h0000_0080);

        // Half store into upper lane via read-modify-write
        set_word(32'h20 >> 2, 32'h1122_3344);
        issue(1'b1, 2'd2, 1'b0, 32'h22, 32'h0000_ABCD, 1'b0, acc_a);
        busy_wait();
        @(negedge clk);
        check("half_store_mem", phys_mem[8], 32'hABCD_3344);

        // Misaligned word load
        issue(1'b0, 2'd3, 1'b0, 32'h06, 32'h0, 1'b0, acc_a);
        check("misalign_mem_addr", mem_addr, 32'h0);
        busy_wait();

        // Two back-to-back loads with valid held high
        issue(1'b0, 2'd3, 1'b0, 32'h44, 32'h1111_1111, 1'b1, acc_a);
        issue(1'b0, 2'd2, 1'b0, 32'h4A, 32'h2222_2222, 1'b0, acc_b);
        check("held_accept_gap", 32'(acc_b - acc_a), 32'(MEM_WAIT + 2));
        busy_wait();

        // Reset in RD_WAIT of a byte store aborts it
        sv = model_mem[16];
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_signed = 1'b0;
        req_addr = 32'h41; req_wdata = 32'h5A;
        check("abort_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 1'b0;
        #1 reset = 1'b1;
        #1 check_reset_outputs("abort");
        @(negedge clk);
        reset = 1'b0;
        last_load = '0;
        repeat (6) @(negedge clk);
        check("abort_mem", phys_mem[16], sv);

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            logic [1:0] sz;
            bit hold;
            sz = ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            hold = ($urandom_range(0, 3) == 0);
            issue(1'($urandom), sz, 1'($urandom), 32'h10 + 32'($urandom_range(0, 32'hEF)),
                  $urandom, hold, acc_a);
            if (!hold) busy_wait();
        end
        busy_wait();
        repeat (5) @(negedge clk);

        check("resp_q_empty", 32'(resp_q.size()), 32'h0);
        check("wr_q_empty", 32'(wr_q.size()), 32'h0);
        bad = 0;
        for (int i = 0; i < 64; i++) if (phys_mem[i] !== model_mem[i]) bad++;
        check("mem_image", 32'(bad), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 2: cycles from mem_addr issue to valid mem_rdata (legal 1..15).
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  in  1  CPU requests an access.
REQ-005 SHALL have port req_ready  out  1  block idle; a request is accepted at a rising edge where req_valid && req_ready.
REQ-006 SHALL have port req_write  in  1  0 = load, 1 = store.
REQ-007 SHALL have port req_size  in  2  1 = byte, 2 = halfword, 3 = word, 0 = illegal.
REQ-008 SHALL have port req_signed  in  1  sign-extend load result (see Configuration).
REQ-009 SHALL have port req_addr  in  32  byte address.
REQ-010 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-011 SHALL have ports mem_addr out 32, mem_wr out 1, mem_wdata out 32, mem_rdata in 32: word-wide memory, little-endian byte lanes.
REQ-012 SHALL have ports resp_valid out 1 (one-cycle pulse), resp_data out 32, resp_err out 1.

Function
REQ-013 SHALL latch req_write, req_size, req_signed, req_addr, req_wdata on acceptance; inputs are ignored while req_ready = 0.
REQ-014 SHALL implement states IDLE, RD_WAIT, WR, RESP; req_ready = 1 only in IDLE.
REQ-015 SHALL drive mem_addr = {addr[31:2], 2'b00} in RD_WAIT and WR, and 0 otherwise.
REQ-016 SHALL flag misalignment when size = 0, when size = 2 and addr[0] = 1, or when size = 3 and addr[1:0] != 0; in that case go IDLE -> RESP with resp_err = 1, no memory access, and resp_data unchanged.
REQ-017 Load: IDLE -> RD_WAIT for exactly MEM_WAIT cycles; SHALL capture mem_rdata at the edge leaving RD_WAIT, then enter RESP; resp_valid is in cycle MEM_WAIT+1 after the accept edge.
REQ-018 Load result: byte = lane addr[1:0], half = lane addr[1] (bits 15:0 or 31:16), word = full; right-aligned and zero-extended unless REQ-027 applies.
REQ-019 Word store: IDLE -> WR (one cycle, mem_wr = 1, mem_wdata = wdata) -> RESP; resp_valid in cycle 2.
REQ-020 Sub-word store: SHALL read-modify-write: RD_WAIT (MEM_WAIT cycles, captures old word) -> WR with only the addressed lane(s) replaced by wdata[7:0] or wdata[15:0] -> RESP; resp_valid in cycle MEM_WAIT+2.
REQ-021 mem_wr SHALL be 1 only in WR, exactly one cycle per store; mem_wdata = 0 outside WR.
REQ-022 RESP lasts one cycle, then returns to IDLE; resp_err = 0 on success; resp_data holds its value until the next successful load response; stores leave resp_data unchanged.
REQ-023 A request with req_valid held high in RESP SHALL NOT be accepted until the following IDLE cycle (minimum 1 idle cycle between accesses).
REQ-024 The RD_WAIT counter SHALL be 4 bits and SHALL reload on each RD_WAIT entry.

Reset
REQ-025 On reset assertion, independent of clk: state = IDLE, counter = 0; req_ready = 1; mem_addr, mem_wr, mem_wdata, resp_valid, resp_data, resp_err = 0.
REQ-026 Reset mid-access SHALL abort the access: no mem_wr pulse and no resp_valid for it, including after reset release.

Configuration
REQ-027 With SIGNED_LOAD_EN defined: byte/half loads with req_signed = 1 SHALL sign-extend from bit 7 or bit 15 of the selected lane. Without it: req_signed is ignored and all loads zero-extend.

Verification
REQ-028 MEM_WAIT = 2, load word at addr 0x10, mem word 0xDEADBEEF -> resp_valid in cycle 3 after accept, resp_data = 0xDEADBEEF, resp_err = 0, mem_wr never 1.
REQ-029 Load byte at addr 0x13, signed, mem word 0x80FF1234 -> resp_data = 0xFFFFFF80 with SIGNED_LOAD_EN, 0x00000080 without it.
REQ-030 Store half 0xABCD at addr 0x22, old word 0x11223344 -> single mem_wr in cycle 3, mem_addr = 0x20, mem_wdata = 0xABCD3344, resp_valid in cycle 4.
REQ-031 Load word at addr 0x06 -> resp_valid with resp_err = 1 in cycle 1, mem_addr stays 0, resp_data unchanged.
REQ-032 Reset pulsed during RD_WAIT of a byte store -> no mem_wr, no resp_valid, req_ready = 1, all outputs 0 immediately.
REQ-033 req_valid held high continuously for two loads -> second request accepted only in the IDLE cycle after RESP; req_wdata changes while busy have no effect.
